// File: rtl/vm2002.sv
// VM2002 vending machine: 8-slot stock/price table, coin credit and one-cycle registered results.
// Supplier loads take priority over purchases; coin credit is evaluated before purchase checks.
package vm2002_pkg;
  typedef enum logic [2:0] {
    COIN_NONE = 3'd0,
    NICKEL    = 3'd1,
    DIME      = 3'd2,
    QUARTER   = 3'd3,
    DOLLAR    = 3'd4
  } coin_t;

  typedef logic [7:0]  items_t;
  typedef logic [2:0]  item_t;
  typedef logic [15:0] cost_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CREDIT  = 3'd1,
    VEND    = 3'd2,
    EMPTY   = 3'd3,
    NOFUNDS = 3'd4,
    SERVICE = 3'd5,
    ERROR   = 3'd6
  } status_t;
endpackage

module vm2002
  import vm2002_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  coin_t       coins,
  input  items_t      buttons,
  input  logic        select,
  input  item_t       item,
  input  logic [3:0]  count,
  input  cost_t       cost,
  input  logic        valid,
  output logic [2:0]  product,
  output status_t     status,
  output logic [15:0] balance,
  output logic [7:0]  info
);

  logic [3:0]  stock_q [8];
  logic [3:0]  stock_d [8];
  cost_t       cost_q  [8];
  cost_t       cost_d  [8];
  logic [15:0] balance_q, balance_d;
  logic [2:0]  product_q, product_d;
  status_t     status_q,  status_d;
  logic [7:0]  info_q,    info_d;

  logic [15:0] coin_val;
  logic        coin_bad;
  logic [16:0] coin_sum;
  logic        coin_err;
  logic [15:0] bal_cred;
  logic        onehot;
  item_t       sel_idx;
  logic        event_hit;

  always_comb begin
    coin_val = '0;
    coin_bad = 1'b0;
    case (coins)
      COIN_NONE: coin_val = 16'd0;
      NICKEL:    coin_val = 16'd5;
      DIME:      coin_val = 16'd10;
      QUARTER:   coin_val = 16'd25;
      DOLLAR:    coin_val = 16'd100;
      default:   coin_bad = 1'b1;
    endcase
  end

  assign coin_sum = {1'b0, balance_q} + {1'b0, coin_val};
  assign coin_err = coin_bad | coin_sum[16];
  assign bal_cred = coin_err ? balance_q : coin_sum[15:0];
  assign onehot   = $onehot(buttons);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (buttons[i]) sel_idx = item_t'(i);
    end
  end

  always_comb begin
    stock_d   = stock_q;
    cost_d    = cost_q;
    balance_d = bal_cred;
    product_d = product_q;
    info_d    = info_q;
    status_d  = status_q;
    event_hit = 1'b1;

    if (valid) begin
      stock_d[item] = count;
      cost_d[item]  = cost;
      status_d      = SERVICE;
    end else if (coin_err) begin
      // A rejected coin also blocks any purchase attempted in the same cycle.
      status_d = ERROR;
    end else if (select) begin
      if (!onehot) begin
        status_d = ERROR;
      end else if (stock_q[sel_idx] == 4'd0) begin
        status_d = EMPTY;
      end else if (bal_cred < cost_q[sel_idx]) begin
        status_d = NOFUNDS;
      end else begin
        balance_d        = bal_cred - cost_q[sel_idx];
        stock_d[sel_idx] = stock_q[sel_idx] - 4'd1;
        product_d        = sel_idx;
        status_d         = VEND;
      end
    end else begin
      event_hit = 1'b0;
    end

    if (!event_hit) status_d = (balance_d != 16'd0) ? CREDIT : IDLE;

    if (valid) begin
      info_d = {1'b0, item, count};
    end else if (onehot) begin
      info_d = {1'b0, sel_idx, stock_d[sel_idx]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        stock_q[i] <= '0;
        cost_q[i]  <= '0;
      end
      balance_q <= '0;
      product_q <= '0;
      status_q  <= IDLE;
      info_q    <= '0;
    end else begin
      stock_q   <= stock_d;
      cost_q    <= cost_d;
      balance_q <= balance_d;
      product_q <= product_d;
      status_q  <= status_d;
      info_q    <= info_d;
    end
  end

  assign product = product_q;
  assign status  = status_q;
  assign balance = balance_q;
  assign info    = info_q;

endmodule

// File: tb/tb_vm2002.sv
// Scoreboard bench for vm2002: a behavioural model predicts each cycle's outputs into a queue
// that a separate monitor drains and compares; directed scenarios plus randomized traffic.
module tb_vm2002;
  import vm2002_pkg::*;

  logic        clk;
  logic        rst;
  coin_t       coins;
  items_t      buttons;
  logic        select;
  item_t       item;
  logic [3:0]  count;
  cost_t       cost;
  logic        valid;
  logic [2:0]  product;
  status_t     status;
  logic [15:0] balance;
  logic [7:0]  info;

  vm2002 dut (
    .clk     (clk),
    .rst     (rst),
    .coins   (coins),
    .buttons (buttons),
    .select  (select),
    .item    (item),
    .count   (count),
    .cost    (cost),
    .valid   (valid),
    .product (product),
    .status  (status),
    .balance (balance),
    .info    (info)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  product;
    logic [2:0]  status;
    logic [15:0] balance;
    logic [7:0]  info;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, kept as plain integers.
  int m_stock[8];
  int m_price[8];
  int m_bal;
  int m_prod;
  int m_info;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_stock[i] = 0;
      m_price[i] = 0;
    end
    m_bal  = 0;
    m_prod = 0;
    m_info = 0;
  endtask

  task automatic model_step(input int c, input int btn, input bit sel, input int it,
                            input int cnt, input int cst, input bit vld);
    int         value;
    bit         rejected;
    int         nb;
    logic [7:0] b;
    bit         hot;
    int         idx;
    bit         evt;
    int         st;
    exp_t       e;
    value    = 0;
    rejected = 0;
    if      (c == 0) value = 0;
    else if (c == 1) value = 5;
    else if (c == 2) value = 10;
    else if (c == 3) value = 25;
    else if (c == 4) value = 100;
    else rejected = 1;
    if (!rejected && (m_bal + value > 65535)) rejected = 1;
    nb  = rejected ? m_bal : m_bal + value;
    b   = btn[7:0];
    hot = ($countones(b) == 1);
    idx = hot ? $clog2(b) : 0;
    evt = 1;
    st  = 0;
    if (vld) begin
      m_stock[it] = cnt;
      m_price[it] = cst;
      st = SERVICE;
    end else if (rejected) begin
      st = ERROR;
    end else if (sel) begin
      if (!hot)                    st = ERROR;
      else if (m_stock[idx] == 0)  st = EMPTY;
      else if (nb < m_price[idx])  st = NOFUNDS;
      else begin
        nb = nb - m_price[idx];
        m_stock[idx] = m_stock[idx] - 1;
        m_prod = idx;
        st = VEND;
      end
    end else begin
      evt = 0;
    end
    m_bal = nb;
    if (!evt) st = (nb > 0) ? CREDIT : IDLE;
    if (vld)      m_info = it * 16 + cnt;
    else if (hot) m_info = idx * 16 + m_stock[idx];
    e.product = 3'(m_prod);
    e.status  = 3'(st);
    e.balance = 16'(m_bal);
    e.info    = 8'(m_info);
    exp_q.push_back(e);
  endtask

  task automatic drive(input int c, input int btn, input bit sel, input int it = 0,
                       input int cnt = 0, input int cst = 0, input bit vld = 1'b0);
    logic [2:0] cc;
    @(negedge clk);
    cc      = 3'(c);
    coins   = coin_t'(cc);
    buttons = 8'(btn);
    select  = sel;
    item    = 3'(it);
    count   = 4'(cnt);
    cost    = 16'(cst);
    valid   = vld;
    model_step(c, btn, sel, it, cnt, cst, vld);
  endtask

  task automatic idle_inputs();
    coins   = COIN_NONE;
    buttons = '0;
    select  = 1'b0;
    item    = '0;
    count   = '0;
    cost    = '0;
    valid   = 1'b0;
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: every rising edge produces one registered result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("product", int'(product), int'(e.product));
        check("status",  int'(status),  int'(e.status));
        check("balance", int'(balance), int'(e.balance));
        check("info",    int'(info),    int'(e.info));
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("rst_balance", int'(balance), 0);
    check("rst_status",  int'(status),  int'(IDLE));
    check("rst_product", int'(product), 0);
    check("rst_info",    int'(info),    0);
    @(negedge clk);
    rst = 1'b1;

    // Load and vend.
    drive(0, 0, 0, 3, 2, 75, 1);
    drive(4, 0, 0);
    drive(0, 8'h08, 1);
    drain();
    check("lv_product", int'(product), 3);
    check("lv_balance", int'(balance), 25);
    check("lv_status",  int'(status),  int'(VEND));
    check("lv_info",    int'(info),    8'h31);

    // Insufficient funds, then empty slot, then illegal buttons.
    do_reset();
    drive(0, 0, 0, 1, 1, 50, 1);
    drive(3, 0, 0);
    drive(0, 8'h02, 1);
    drain();
    check("nf_status",  int'(status),  int'(NOFUNDS));
    check("nf_balance", int'(balance), 25);
    check("nf_info",    int'(info),    8'h11);
    do_reset();
    drive(4, 0, 0);
    drive(0, 8'h10, 1);
    drain();
    check("em_status",  int'(status),  int'(EMPTY));
    check("em_balance", int'(balance), 100);
    drive(0, 8'h05, 1);
    drain();
    check("ill_status", int'(status), int'(ERROR));

    // Load wins over select; zero-cost vend at balance 0; overflow edge.
    do_reset();
    drive(0, 8'h04, 1, 2, 5, 0, 1);
    drive(0, 8'h04, 1);
    drive(0, 8'h04, 0);
    for (int i = 0; i < 655; i++) drive(4, 0, 0);
    drive(2, 0, 0);
    drive(2, 0, 0);
    drain();
    check("ov_pre", int'(balance), 16'hFFF0);
    drive(2, 0, 0);
    drain();
    check("ov_dime", int'(balance), 16'hFFFA);
    drive(3, 0, 0);
    drain();
    check("ov_status",  int'(status),  int'(ERROR));
    check("ov_balance", int'(balance), 16'hFFFA);
    drive(5, 0, 0);
    drive(7, 8'h04, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int c, btn, it, cnt, cst;
      bit sel, vld;
      c   = ($urandom % 10 < 8) ? $urandom_range(0, 4) : $urandom_range(0, 7);
      btn = ($urandom % 4 != 0) ? (1 << ($urandom % 8)) : ($urandom % 256);
      sel = ($urandom % 3 == 0);
      vld = ($urandom % 8 == 0);
      it  = $urandom % 8;
      cnt = ($urandom % 2 == 0) ? $urandom_range(0, 2) : $urandom_range(0, 15);
      cst = ($urandom % 4 == 0) ? 0 : $urandom_range(1, 150);
      drive(c, btn, sel, it, cnt, cst, vld);
    end

    // Async reset between edges.
    do_reset();
    drive(4, 0, 0);
    drain();
    check("ar_pre", int'(balance), 100);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("ar_balance", int'(balance), 0);
    check("ar_status",  int'(status),  int'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    drive(0, 8'h01, 1);
    drain();
    check("ar_empty", int'(status), int'(EMPTY));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
